// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: sel codes, FSM encoding, flag layout.
package alu_arbiter_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_MAX_SEL = 5;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned NFLAGS      = 4;

    localparam logic [SEL_W-1:0] SEL_AND  = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_OR   = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_NOT  = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_NOR  = 4'b0011;
    localparam logic [SEL_W-1:0] SEL_XOR  = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_NAND = 4'b0101;

    localparam int unsigned FLAG_COUT = 3;
    localparam int unsigned FLAG_NEG  = 2;
    localparam int unsigned FLAG_ZERO = 1;
    localparam int unsigned FLAG_OVF  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the loser on every accepted grant.
module rr_arbiter2
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       ptr_o
);

    logic ptr_q;
    logic ptr_d;

    // ptr_q == 1 means req1 wins a tie
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
        endcase
        if (advance_i && (grant_o != 2'b00)) begin
            ptr_d = grant_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters and
// returns the captured result on a tagged response channel.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MAX_SEL = DEF_MAX_SEL
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [SEL_W-1:0]    req0_sel,
    input  logic                req0_cin,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [SEL_W-1:0]    req1_sel,
    input  logic                req1_cin,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    output logic                alu_cin,
    input  logic [WIDTH-1:0]    alu_y,
    input  logic                alu_cout,
    input  logic                alu_neg,
    input  logic                alu_zero,
    input  logic                alu_ovf,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH-1:0]    rsp_y,
    output logic [NFLAGS-1:0]   rsp_flags,
    output logic                rsp_err
);

    state_e state_q;
    state_e state_d;

    logic [1:0]        arb_req;
    logic [1:0]        arb_grant;
    logic              arb_ptr;
    logic              accept;
    logic              capture;
    logic              rsp_done;

    logic [WIDTH-1:0]  alu_a_q;
    logic [WIDTH-1:0]  alu_b_q;
    logic [SEL_W-1:0]  alu_sel_q;
    logic              alu_cin_q;
    logic              gid_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [WIDTH-1:0]  rsp_y_q;
    logic [NFLAGS-1:0] rsp_flags_q;
    logic              rsp_err_q;
    logic [NFLAGS-1:0] alu_flags;
    logic              sel_illegal;

    assign arb_req = {req1_valid, req0_valid};

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (arb_req),
        .advance_i (accept),
        .grant_o   (arb_grant),
        .ptr_o     (arb_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        capture  = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_req != 2'b00) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is a same-cycle grant strobe; held low while reset is asserted
    assign req0_ready = rst_n & accept & arb_grant[0];
    assign req1_ready = rst_n & accept & arb_grant[1];

    always_comb begin
        alu_flags            = '0;
        alu_flags[FLAG_COUT] = alu_cout;
        alu_flags[FLAG_NEG]  = alu_neg;
        alu_flags[FLAG_ZERO] = alu_zero;
        alu_flags[FLAG_OVF]  = alu_ovf;
    end

    assign sel_illegal = (alu_sel_q > SEL_W'(MAX_SEL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            alu_cin_q   <= 1'b0;
            gid_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= arb_grant[1] ? req1_a   : req0_a;
                alu_b_q   <= arb_grant[1] ? req1_b   : req0_b;
                alu_sel_q <= arb_grant[1] ? req1_sel : req0_sel;
                alu_cin_q <= arb_grant[1] ? req1_cin : req0_cin;
                gid_q     <= arb_grant[1];
            end
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_id_q    <= gid_q;
                rsp_err_q   <= sel_illegal;
                rsp_y_q     <= sel_illegal ? '0 : alu_y;
                rsp_flags_q <= sel_illegal ? '0 : alu_flags;
            end else if (rsp_done) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // On a tie the grant must follow the pointer
    assert property (@(posedge clk) disable iff (!rst_n)
                     (arb_req == 2'b11) |-> (arb_grant[1] == arb_ptr));

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign alu_cin   = alu_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small logic-ALU model on the datapath side.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_sel = '0, req1_sel = '0;
    logic          req0_cin = 1'b0, req1_cin = 1'b0;
    logic [W-1:0]  alu_a, alu_b, alu_y;
    logic [3:0]    alu_sel;
    logic          alu_cin, alu_cout, alu_neg, alu_zero, alu_ovf;
    logic          rsp_valid, rsp_id, rsp_err;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_y;
    logic [3:0]    rsp_flags;

    logic          force_flags = 1'b0;
    logic [W-1:0]  model_y;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_y(alu_y), .alu_cout(alu_cout), .alu_neg(alu_neg),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    // Logic-only ALU; Cout echoes Cin so carry pass-through is observable
    always_comb begin
        case (alu_sel)
            SEL_AND:  model_y = alu_a & alu_b;
            SEL_OR:   model_y = alu_a | alu_b;
            SEL_NOT:  model_y = ~alu_a;
            SEL_NOR:  model_y = ~(alu_a | alu_b);
            SEL_XOR:  model_y = alu_a ^ alu_b;
            SEL_NAND: model_y = ~(alu_a & alu_b);
            default:  model_y = 32'hDEAD_BEEF;
        endcase
        alu_y = model_y;
        if (force_flags) begin
            {alu_cout, alu_neg, alu_zero, alu_ovf} = 4'b0011;
        end else begin
            alu_cout = alu_cin;
            alu_neg  = model_y[W-1];
            alu_zero = (model_y == '0);
            alu_ovf  = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one request on port id, wait for its response (rsp_ready assumed high)
    task automatic run_txn(input bit id, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel, input logic cin,
                           output logic [31:0] y, output logic [3:0] fl,
                           output logic err, output logic rid);
        bit got;
        y = '0; fl = '0; err = 1'b0; rid = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_sel = sel; req1_cin = cin; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sel = sel; req0_cin = cin; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; y = rsp_y; fl = rsp_flags; err = rsp_err; rid = rsp_id;
            end
        end
        if (!got) check("rsp_timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] y;
        logic [3:0]  fl;
        logic        err, rid;
        int          gid[4];
        int          gcyc[4];
        int          ng;
        logic [31:0] y_hold;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_y", rsp_y, 0);
        check("rst_alu_a", alu_a, 0);
        rst_n = 1'b1;

        // Single request: AND
        req0_a = 32'h0000_00F0; req0_b = 32'h0000_0FF0; req0_sel = SEL_AND; req0_cin = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_ready1", req1_ready, 0);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        check("t1_ready_once", req0_ready, 0);
        check("t1_no_early_rsp", rsp_valid, 0);
        check("t1_alu_a", alu_a, 32'h0000_00F0);
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_rsp_id", rsp_id, 0);
        check("t1_rsp_y", rsp_y, 32'h0000_00F0);
        check("t1_rsp_flags", rsp_flags, 4'b0000);
        check("t1_rsp_err", rsp_err, 0);
        @(negedge clk);
        check("t1_rsp_done", rsp_valid, 0);

        // Contention from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_a = 32'h1; req0_b = 32'h2; req0_sel = SEL_OR;
        req1_a = 32'h3; req1_b = 32'h5; req1_sel = SEL_XOR;
        req0_valid = 1'b1; req1_valid = 1'b1;
        ng = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req0_ready && req1_ready) check("cont_both_ready", 1, 0);
            if ((req0_ready || req1_ready) && ng < 4) begin
                gid[ng] = req1_ready ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_ngrants", ng, 4);
        for (int i = 0; i < 4; i++) check($sformatf("cont_gid%0d", i), gid[i], i % 2);
        for (int i = 1; i < 4; i++) check($sformatf("cont_gap%0d", i), gcyc[i] - gcyc[i-1], 3);

        // Back-pressure
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        req1_a = 32'hFFFF_0000; req1_b = 32'h0F0F_0F0F; req1_sel = SEL_XOR; req1_cin = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("bp_ready1", req1_ready, 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        req0_a = 32'h7; req0_b = 32'h3; req0_sel = SEL_AND; req0_valid = 1'b1;
        @(negedge clk);
        y_hold = 32'hF0F0_0F0F;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_y", rsp_y, y_hold);
            check("bp_rsp_id", rsp_id, 1);
            check("bp_req0_blocked", req0_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", rsp_valid, 0);
        check("bp_idle", req0_ready, 1);
        req0_valid = 1'b0;
        @(negedge clk);

        // Illegal sel, then a legal one
        run_txn(1'b0, 32'h1234, 32'h5678, 4'b1010, 1'b0, y, fl, err, rid);
        check("ill_err", err, 1);
        check("ill_y", y, 0);
        check("ill_flags", fl, 0);
        check("ill_id", rid, 0);
        run_txn(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, SEL_OR, 1'b0, y, fl, err, rid);
        check("legal_err", err, 0);
        check("legal_y", y, 32'hFFFF_FFFF);
        check("legal_flags", fl, 4'b0100);
        check("legal_id", rid, 1);

        // Flag pass-through from the ALU model
        run_txn(1'b1, 32'h0, 32'h0, SEL_NOT, 1'b1, y, fl, err, rid);
        check("not_y", y, 32'hFFFF_FFFF);
        check("not_flags", fl, 4'b1100);
        run_txn(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, SEL_NOR, 1'b0, y, fl, err, rid);
        check("nor_y", y, 32'h0);
        check("nor_flags", fl, 4'b0010);
        force_flags = 1'b1;
        run_txn(1'b0, 32'h5, 32'h3, SEL_AND, 1'b0, y, fl, err, rid);
        check("force_y", y, 32'h1);
        check("force_flags", fl, 4'b0011);
        force_flags = 1'b0;

        // Reset during EXEC
        req0_a = 32'hA5A5_0000; req0_b = 32'h0000_5A5A; req0_sel = SEL_OR; req0_cin = 1'b1;
        req0_valid = 1'b1;
        @(posedge clk); #1;
        req1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_cin", alu_cin, 0);
        check("mid_rst_ready0", req0_ready, 0);
        check("mid_rst_ready1", req1_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready0", req0_ready, 1);
        check("post_rst_ready1", req1_ready, 0);
        check("post_rst_no_rsp", rsp_valid, 0);
        req1_valid = 1'b0;
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_rsp_valid", rsp_valid, 1);
        check("post_rst_rsp_id", rsp_id, 0);
        check("post_rst_rsp_y", rsp_y, 32'hA5A5_5A5A);
        check("post_rst_flags", rsp_flags, 4'b1100);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, req0 and req1.
- Each requester talks to it through a valid/ready handshake; the block round-robin arbitrates, registers the operands and drives the ALU for one cycle.
- It then captures Y and the four flags and returns them on a shared response channel tagged with the requester ID.
- It sits between the ALU datapath and its two command sources.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU A/B/Y width.
- MAX_SEL, 5, highest legal sel code. 0000 AND, 0001 OR, 0010 NOT, 0011 NOR, 0100 XOR, 0101 NAND.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- req0_sel / req1_sel  in  4  ALU operation
- req0_cin / req1_cin  in  1  carry-in
- alu_a, alu_b  out  WIDTH  registered operands to ALU
- alu_sel  out  4  registered sel to ALU
- alu_cin  out  1  registered Cin to ALU
- alu_y  in  WIDTH  ALU result
- alu_cout, alu_neg, alu_zero, alu_ovf  in  1  ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_y  out  WIDTH  captured result
- rsp_flags  out  4  {Cout, Negative, Zero, Overflow}
- rsp_err  out  1  illegal sel (sel > MAX_SEL)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; priority pointer favours req0.
  - All outputs 0: req*_ready, rsp_valid, rsp_id, rsp_y, rsp_flags, rsp_err, alu_*.
  - Any in-flight transaction is dropped.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req*_valid, grant one requester.
  - Assert the granted reqN_ready combinationally in that cycle only.
  - Register a, b, sel, cin onto alu_*, latch the grant id, go EXEC.
  - If no request is valid, stay in IDLE.
- Arbitration:
  - A single valid requester always wins.
  - If both are valid, the pointer decides; the pointer flips to the non-granted requester on each grant.
  - At most one req*_ready is high per cycle.
- EXEC:
  - alu_* are stable; the ALU settles combinationally.
  - At the clock edge, capture alu_y and the flags into rsp_y/rsp_flags, set rsp_valid=1, go RESP.
- Illegal sel: if the latched sel > MAX_SEL, capture rsp_y=0 and rsp_flags=0, set rsp_err=1. Otherwise rsp_err=0.
- RESP:
  - rsp_valid, rsp_id, rsp_y, rsp_flags and rsp_err are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, go IDLE.
  - rsp_ready=0 stalls indefinitely; no new request is accepted while stalled.
- Latency: accept at edge t gives rsp_valid high from t+2. Minimum issue interval is 3 cycles with rsp_ready tied high.
- alu_* hold their last value outside EXEC; they are not cleared after use.
- Requesters hold a/b/sel/cin stable while valid && !ready. A request dropped before acceptance is legal and is simply not served.
- rsp_ready while rsp_valid=0 is ignored.
- Reset asserted in EXEC or RESP: response lost, return to IDLE, pointer back to req0.
- Overflow, Cout, Negative and Zero are passed through exactly as the ALU drives them; no recomputation.

Decomposition:
- Shared package holds:
  - sel codes SEL_AND=4'b0000 .. SEL_NAND=4'b0101;
  - state encoding IDLE/EXEC/RESP;
  - flag bit indices FLAG_COUT=3, FLAG_NEG=2, FLAG_ZERO=1, FLAG_OVF=0.
- One sub-module, rr_arbiter2: inputs req[1:0], advance, clk, rst_n; outputs one-hot grant[1:0] and the pointer.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Single request: reset, req0 a=0x0000_00F0, b=0x0000_0FF0, sel=0000 (AND), rsp_ready=1.
  - req0_ready for exactly 1 cycle; rsp_valid 2 cycles after accept.
  - rsp_id=0, rsp_y=0x0000_00F0, rsp_err=0.
- Contention: req0 and req1 both valid and held continuously, rsp_ready=1.
  - Grants alternate 0,1,0,1; each issue is 3 cycles apart.
  - No requester is granted twice in a row while the other is waiting.
- Back-pressure: req1 XOR a=0xFFFF_0000, b=0x0F0F_0F0F, rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_y=0xF0F0_0F0F stay stable; req0_ready stays 0 while waiting.
  - Raise rsp_ready: one handshake, then IDLE.
- Illegal sel: req0 sel=4'b1010.
  - rsp_err=1, rsp_y=0, rsp_flags=0.
  - Next legal request returns rsp_err=0.
- Reset mid-operation: assert rst_n=0 during EXEC.
  - All outputs 0 immediately (async), no response emitted.
  - After release with both requesters valid, req0 is granted first.
- Flag pass-through: force ALU inputs alu_zero=1, alu_ovf=1.
  - rsp_flags=4'b0011 captured exactly as driven.
